seq_gen: RTL

- Parametrised colour-sequence source for the Genius game.
- Plays the first round_len entries of a reproducible sequence to the display/compare logic over a valid/ready handshake, one colour per beat.
- MODE selects the fixed classic 16-entry table or a seeded LFSR sequence.
- The same seed always replays the same sequence, so each round re-presents the earlier colours before adding one.

---
 rtl/seq_pkg.sv | 38 +++
 rtl/seq_gen_if.sv | 29 ++
 rtl/seq_lfsr.sv | 28 ++
 rtl/seq_gen.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the Genius colour-sequence source.
// Holds the FSM state enum, LFSR constants, the classic colour table
// and the width helpers used to size ports from the parameters.
package seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_MASK    = 16'hB400;
  localparam logic [15:0] SEED_DEFAULT = 16'h0001;

  // Classic 16-entry game sequence, one-hot over four colours.
  localparam logic [3:0] CLASSIC_TBL [16] = '{
    4'b0001, 4'b0100, 4'b0010, 4'b1000,
    4'b0001, 4'b1000, 4'b0100, 4'b1000,
    4'b0010, 4'b1000, 4'b0001, 4'b0010,
    4'b1000, 4'b0001, 4'b0100, 4'b0010
  };

  // Round-length width: must hold MAX_LEN itself.
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Index width: positions 0..MAX_LEN-1.
  function automatic int idx_w(input int max_len);
    return $clog2(max_len);
  endfunction

  // Colour-code width used to pick bits out of the LFSR.
  function automatic int ck_w(input int n_colors);
    return $clog2(n_colors);
  endfunction

endpackage

// File: rtl/seq_gen_if.sv
// Colour stream interface: one colour per accepted beat.
// Source drives color_valid/color/index/last, sink drives color_ready.
// A beat transfers when color_valid & color_ready.
interface seq_gen_if #(
  parameter int N_COLORS = 4,
  parameter int IDX_W    = 4
);
  logic                color_valid;
  logic                color_ready;
  logic [N_COLORS-1:0] color;
  logic [IDX_W-1:0]    index;
  logic                last;

  modport master (
    output color_valid,
    output color,
    output index,
    output last,
    input  color_ready
  );

  modport slave (
    input  color_valid,
    input  color,
    input  index,
    input  last,
    output color_ready
  );
endinterface

// File: rtl/seq_lfsr.sv
// Galois right-shift LFSR (mask 0xB400) with load and step controls.
// Latency: state updates one cycle after load/step; load wins over step.
// No backpressure: the owner decides when to step.
// Ports: clk, rst (async high), load/load_val, step, state (current value).
module seq_lfsr
  import seq_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  output logic [W-1:0] state
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= W'(SEED_DEFAULT);
    end else if (load) begin
      state <= load_val;
    end else if (step) begin
      state <= (state >> 1) ^ (state[0] ? W'(LFSR_MASK) : '0);
    end
  end

endmodule

// File: rtl/seq_gen.sv
// Genius colour-sequence source: plays round_len colours from a table or seeded LFSR.
// Latency: start in cycle T gives the first colour valid in T+1; one colour per cycle.
// Backpressure: colour/index/last hold while color_ready is low; ready only affects next state.
// Ports: clk, rst (async high); seed_load/seed, start/round_len, abort control inputs;
//        cif (master) carries color_valid/color_ready/color/index/last;
//        done (pulse after final accept), busy (not idle), err (pulse on rejected start).
module seq_gen
  import seq_pkg::*;
#(
  parameter  int N_COLORS = 4,
  parameter  int MAX_LEN  = 16,
  parameter  int MODE     = 0,
  parameter  int LFSR_W   = 16,
  localparam int LEN_W    = len_w(MAX_LEN),
  localparam int IDX_W    = idx_w(MAX_LEN),
  localparam int CK       = ck_w(N_COLORS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              start,
  input  logic [LEN_W-1:0]  round_len,
  input  logic              abort,
  seq_gen_if.master         cif,
  output logic              done,
  output logic              busy,
  output logic              err
);

  if (MODE == 0 && N_COLORS != 4) begin : g_bad_table
    $error("seq_gen: the classic table needs N_COLORS == 4");
  end
  if (N_COLORS < 2 || N_COLORS > 8) begin : g_bad_colors
    $error("seq_gen: N_COLORS must be 2..8");
  end
  if (MAX_LEN < 2 || MAX_LEN > 256) begin : g_bad_len
    $error("seq_gen: MAX_LEN must be 2..256");
  end
  if (LFSR_W != 16) begin : g_bad_lfsr
    $error("seq_gen: only a 16-bit LFSR is supported");
  end

  state_t              state;
  logic [LFSR_W-1:0]   seed_reg;
  logic [LEN_W-1:0]    len;
  logic [IDX_W-1:0]    idx;
  logic [LFSR_W-1:0]   lfsr;
  logic [N_COLORS-1:0] color_d;
  logic [IDX_W+3:0]    idx_pad;
  logic [3:0]          tbl_idx;

  logic play;
  logic len_ok;
  logic at_last;
  logic lfsr_load;
  logic lfsr_step;

  assign play    = (state == S_PLAY);
  assign len_ok  = (round_len != '0) && (round_len <= LEN_W'(MAX_LEN));
  assign at_last = (LEN_W'(idx) == len - LEN_W'(1));

  // The LFSR is loaded from the seed register as it stood before this cycle,
  // so a seed_load in the same cycle as start only affects the next round.
  assign lfsr_load = (state == S_IDLE) & start & len_ok & ~abort;
  // No step on the final beat: the LFSR only has to cover entries 0..len-1.
  assign lfsr_step = play & cif.color_ready & ~at_last & ~abort;

  seq_lfsr #(.W(LFSR_W)) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (lfsr_load),
    .load_val (seed_reg),
    .step     (lfsr_step),
    .state    (lfsr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      seed_reg <= LFSR_W'(SEED_DEFAULT);
      len      <= '0;
      idx      <= '0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              if (len_ok) begin
                len   <= round_len;
                idx   <= '0;
                state <= S_PLAY;
              end else begin
                err <= 1'b1;
              end
            end
            // A zero seed would lock the LFSR, so it is replaced.
            if (seed_load) begin
              seed_reg <= (seed == '0) ? LFSR_W'(SEED_DEFAULT) : seed;
            end
          end
          S_PLAY: begin
            if (cif.color_ready) begin
              if (at_last) begin
                state <= S_DONE;
              end else begin
                idx <= idx + IDX_W'(1);
              end
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Table index wraps every 16 entries regardless of IDX_W.
  assign idx_pad = {4'b0000, idx};
  assign tbl_idx = idx_pad[3:0];

  always_comb begin
    int v;
    color_d = '0;
    v       = int'(lfsr[CK-1:0]);
    if (v >= N_COLORS) begin
      v = v - N_COLORS;
    end
    if (play) begin
      if (MODE == 0) begin
        color_d = N_COLORS'(CLASSIC_TBL[tbl_idx]);
      end else begin
        color_d = N_COLORS'(1) << v;
      end
    end
  end

  assign cif.color_valid = play;
  assign cif.color       = color_d;
  assign cif.index       = play ? idx : '0;
  assign cif.last        = play & at_last;
  assign done            = (state == S_DONE);
  assign busy            = (state != S_IDLE);

  // Only the low CK LFSR bits and low four index bits select a colour.
  logic unused_bits;
  assign unused_bits = ^{lfsr, idx_pad[IDX_W+3:4]};

endmodule
